// File: rtl/i2c_cmd_arbiter.sv
// Two-requester round-robin front end for an I2C controller: grants one
// command at a time, retries on NACK, times out hung transfers, and spaces attempts.
module i2c_cmd_arbiter #(
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int GAP_CYCLES     = 16
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [23:0] req0_data,
    output logic        req0_ready,
    output logic        req0_done,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic [23:0] req1_data,
    output logic        req1_ready,
    output logic        req1_done,
    output logic        req1_err,
    output logic [23:0] i2c_data,
    output logic        i2c_go,
    input  logic        i2c_end,
    input  logic        i2c_ack,
    output logic        busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, WAIT_END, GAP} state_t;

    state_t        r_state;
    logic          r_owner;
    logic          r_last_grant;
    logic          r_retry;
    logic [RW-1:0] r_retry_cnt;
    logic [TW-1:0] r_timer;
    logic [GW-1:0] r_gap;
    logic [23:0]   r_data;
    logic          r_go;
    logic          r_busy;
    logic          r_ready0, r_ready1;
    logic          r_done0, r_done1;
    logic          r_err0, r_err1;

    // On a tie the requester that did not win last time gets the bus.
    logic w_grant;
    assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_retry      <= 1'b0;
            r_retry_cnt  <= '0;
            r_timer      <= '0;
            r_gap        <= '0;
            r_data       <= '0;
            r_go         <= 1'b0;
            r_busy       <= 1'b0;
            r_ready0     <= 1'b0;
            r_ready1     <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_ready0 <= 1'b0;
            r_ready1 <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req0_valid || req1_valid) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_data       <= w_grant ? req1_data : req0_data;
                        r_go         <= 1'b1;
                        r_busy       <= 1'b1;
                        r_retry_cnt  <= '0;
                        r_timer      <= '0;
                        r_ready0     <= ~w_grant;
                        r_ready1     <= w_grant;
                        r_state      <= WAIT_END;
                    end
                end
                WAIT_END: begin
                    // A controller end wins over a timeout landing on the same cycle.
                    if (i2c_end) begin
                        r_go    <= 1'b0;
                        r_gap   <= '0;
                        r_state <= GAP;
                        if (!i2c_ack) begin
                            r_retry <= 1'b0;
                            r_done0 <= ~r_owner;
                            r_done1 <= r_owner;
                        end else if (r_retry_cnt < RETRY_LIMIT) begin
                            r_retry     <= 1'b1;
                            r_retry_cnt <= r_retry_cnt + RW'(1);
                        end else begin
                            r_retry <= 1'b0;
                            r_err0  <= ~r_owner;
                            r_err1  <= r_owner;
                        end
                    end else if (r_timer == TIMER_LAST) begin
                        r_go    <= 1'b0;
                        r_gap   <= '0;
                        r_retry <= 1'b0;
                        r_err0  <= ~r_owner;
                        r_err1  <= r_owner;
                        r_state <= GAP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        if (r_retry) begin
                            r_go    <= 1'b1;
                            r_timer <= '0;
                            r_state <= WAIT_END;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_go    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req0_ready = r_ready0;
    assign req1_ready = r_ready1;
    assign req0_done  = r_done0;
    assign req1_done  = r_done1;
    assign req0_err   = r_err0;
    assign req1_err   = r_err1;
    assign i2c_data   = r_data;
    assign i2c_go     = r_go;
    assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Bench for i2c_cmd_arbiter: queued requesters and an emulated I2C controller,
// checked against a command-level model of arbitration, retry and timeout rules.
module tb_i2c_cmd_arbiter;
    localparam int TIMEOUT = 20;
    localparam int GAP     = 2;
    localparam int RETRIES = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [23:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req0_done, req0_err;
    logic        req1_ready, req1_done, req1_err;
    logic [23:0] i2c_data;
    logic        i2c_go, busy;
    logic        i2c_end = 1'b0, i2c_ack = 1'b0;

    i2c_cmd_arbiter #(.MAX_RETRY(RETRIES), .TIMEOUT_CYCLES(TIMEOUT), .GAP_CYCLES(GAP)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .req1_done(req1_done), .req1_err(req1_err),
        .i2c_data(i2c_data), .i2c_go(i2c_go), .i2c_end(i2c_end), .i2c_ack(i2c_ack),
        .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0, bad = 0, cyc = 0;
    logic [23:0] q0[$], q1[$];
    int   respDelay[$];
    logic respAck[$];
    int   attemptCyc = 0, curDelay = -1;
    logic curAck = 1'b0;

    logic [23:0] dataQ[$];
    int goRuns[$], lowRuns[$], readyQ[$], outQ[$];
    int goLen = 0, lowLen = 0, widthErr = 0, dataChg = 0;
    int endCyc = -1, doneCyc = -1, busyFallCyc = -1;
    bit haveFall = 0;
    logic prevGo = 1'b0, prevBusy = 1'b0;
    logic [23:0] prevData = '0;
    logic [5:0]  prevPulses = '0;

    function automatic int peekI(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic int peekD(input logic [23:0] q[$], input int i);
        return (i < q.size()) ? int'(q[i]) : -1;
    endfunction

    // One clock: observe outputs, then advance requesters and the emulated controller.
    task automatic tick();
        logic [5:0] pulses;
        @(negedge CLOCK_50);
        cyc++;
        pulses = {req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err};
        if (i2c_go && !prevGo) begin
            dataQ.push_back(i2c_data);
            if (haveFall) lowRuns.push_back(lowLen);
            goLen = 0;
        end
        if (i2c_go && prevGo && i2c_data !== prevData) dataChg++;
        if (i2c_go) goLen++;
        if (!i2c_go && prevGo) begin
            goRuns.push_back(goLen);
            haveFall = 1;
            lowLen = 0;
        end
        if (!i2c_go) lowLen++;
        if (req0_ready) readyQ.push_back(0);
        if (req1_ready) readyQ.push_back(1);
        if (req0_done) begin outQ.push_back(0); doneCyc = cyc; end
        if (req0_err)  outQ.push_back(1);
        if (req1_done) begin outQ.push_back(2); doneCyc = cyc; end
        if (req1_err)  outQ.push_back(3);
        if ((pulses & prevPulses) != 6'd0) widthErr++;
        if (!busy && prevBusy) busyFallCyc = cyc;
        prevGo = i2c_go; prevBusy = busy; prevData = i2c_data; prevPulses = pulses;

        if (req0_ready && q0.size() > 0) void'(q0.pop_front());
        if (req1_ready && q1.size() > 0) void'(q1.pop_front());
        req0_valid = (q0.size() > 0);
        req0_data  = (q0.size() > 0) ? q0[0] : 24'h0;
        req1_valid = (q1.size() > 0);
        req1_data  = (q1.size() > 0) ? q1[0] : 24'h0;

        i2c_end = 1'b0;
        i2c_ack = 1'($urandom_range(0, 1));
        if (i2c_go === 1'b1) begin
            if (attemptCyc == 0) begin
                if (respDelay.size() > 0) begin
                    curDelay = respDelay.pop_front();
                    curAck   = respAck.pop_front();
                end else begin
                    curDelay = -1;
                    curAck   = 1'b0;
                end
            end
            if (attemptCyc == curDelay) begin
                i2c_end = 1'b1;
                i2c_ack = curAck;
                endCyc  = cyc;
            end
            attemptCyc++;
        end else begin
            attemptCyc = 0;
        end
    endtask

    task automatic clearMon();
        dataQ.delete(); goRuns.delete(); lowRuns.delete(); readyQ.delete(); outQ.delete();
        respDelay.delete(); respAck.delete();
        haveFall = 0; goLen = 0; lowLen = 0; widthErr = 0; dataChg = 0;
        endCyc = -1; doneCyc = -1; busyFallCyc = -1;
    endtask

    task automatic addResp(input int d, input logic a);
        respDelay.push_back(d);
        respAck.push_back(a);
    endtask

    task automatic waitSettle(input int nOut, input int limit, output bit ok);
        int g = 0;
        while (!(outQ.size() >= nOut && busy == 1'b0 && q0.size() == 0 && q1.size() == 0) && g < limit) begin
            tick();
            g++;
        end
        ok = (outQ.size() >= nOut && busy == 1'b0 && q0.size() == 0 && q1.size() == 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++; if (i2c_go !== 1'b0) begin bad++; $display("[TB] FAIL reset_go: got %b want 0", i2c_go); end
        total++; if (i2c_data !== 24'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 000000", i2c_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        total++;
        if ({req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_pulses: got %b want 000000",
                     {req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err});
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        clearMon();
        addResp(5, 1'b0);
        q0.push_back(24'h340E4D);
        waitSettle(1, 200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL single_settle: got outcomes=%0d busy=%b want 1 and 0", outQ.size(), busy); end
        total++; if (readyQ.size() != 1 || peekI(readyQ, 0) != 0) begin bad++; $display("[TB] FAIL single_ready: got n=%0d id=%0d want n=1 id=0", readyQ.size(), peekI(readyQ, 0)); end
        total++; if (dataQ.size() != 1 || peekD(dataQ, 0) != 32'h340E4D) begin bad++; $display("[TB] FAIL single_data: got n=%0d %h want n=1 340e4d", dataQ.size(), peekD(dataQ, 0)); end
        total++; if (peekI(goRuns, 0) != 6) begin bad++; $display("[TB] FAIL single_go_len: got %0d want 6", peekI(goRuns, 0)); end
        total++; if (outQ.size() != 1 || peekI(outQ, 0) != 0) begin bad++; $display("[TB] FAIL single_outcome: got n=%0d code=%0d want n=1 code=0", outQ.size(), peekI(outQ, 0)); end
        total++; if (doneCyc - endCyc != 1) begin bad++; $display("[TB] FAIL single_done_lat: got %0d want 1", doneCyc - endCyc); end
        total++; if (busyFallCyc - endCyc != GAP + 1) begin bad++; $display("[TB] FAIL single_busy_low: got %0d want %0d", busyFallCyc - endCyc, GAP + 1); end
    endtask

    task automatic test_contention();
        bit ok;
        int expR[3] = '{0, 1, 0};
        int expD[3] = '{32'h123456, 32'h401500, 32'h340E4D};
        int expO[3] = '{0, 2, 0};
        reset = 1'b1;
        clearMon();
        q0.push_back(24'h123456); q0.push_back(24'h340E4D);
        q1.push_back(24'h401500);
        for (int i = 0; i < 3; i++) addResp(2, 1'b0);
        tick(); tick();
        reset = 1'b0;
        waitSettle(3, 400, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL cont_settle: got outcomes=%0d want 3", outQ.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (peekI(readyQ, i) != expR[i]) begin bad++; $display("[TB] FAIL cont_grant%0d: got %0d want %0d", i, peekI(readyQ, i), expR[i]); end
            total++; if (peekD(dataQ, i) != expD[i]) begin bad++; $display("[TB] FAIL cont_data%0d: got %h want %h", i, peekD(dataQ, i), expD[i]); end
            total++; if (peekI(outQ, i) != expO[i]) begin bad++; $display("[TB] FAIL cont_out%0d: got %0d want %0d", i, peekI(outQ, i), expO[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            total++; if (peekI(lowRuns, i) != GAP + 1) begin bad++; $display("[TB] FAIL cont_gap%0d: got %0d want %0d", i, peekI(lowRuns, i), GAP + 1); end
        end
    endtask

    task automatic test_retry();
        bit ok;
        int expG[3] = '{3, 4, 2};
        clearMon();
        addResp(2, 1'b1); addResp(3, 1'b1); addResp(1, 1'b0);
        q1.push_back(24'h401500);
        waitSettle(1, 400, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL retry_settle: got outcomes=%0d want 1", outQ.size()); end
        total++; if (dataQ.size() != 3) begin bad++; $display("[TB] FAIL retry_attempts: got %0d want 3", dataQ.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (peekD(dataQ, i) != 32'h401500) begin bad++; $display("[TB] FAIL retry_data%0d: got %h want 401500", i, peekD(dataQ, i)); end
            total++; if (peekI(goRuns, i) != expG[i]) begin bad++; $display("[TB] FAIL retry_go%0d: got %0d want %0d", i, peekI(goRuns, i), expG[i]); end
        end
        for (int i = 0; i < 2; i++) begin
            total++; if (peekI(lowRuns, i) != GAP) begin bad++; $display("[TB] FAIL retry_gap%0d: got %0d want %0d", i, peekI(lowRuns, i), GAP); end
        end
        total++; if (outQ.size() != 1 || peekI(outQ, 0) != 2) begin bad++; $display("[TB] FAIL retry_outcome: got n=%0d code=%0d want n=1 code=2", outQ.size(), peekI(outQ, 0)); end
    endtask

    task automatic test_exhaust();
        bit ok;
        clearMon();
        addResp(1, 1'b1); addResp(4, 1'b1); addResp(0, 1'b1); addResp(1, 1'b0);
        q0.push_back(24'hA55A0F);
        waitSettle(1, 400, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL exh_settle: got outcomes=%0d want 1", outQ.size()); end
        total++; if (dataQ.size() != RETRIES + 1) begin bad++; $display("[TB] FAIL exh_attempts: got %0d want %0d", dataQ.size(), RETRIES + 1); end
        total++; if (peekI(goRuns, 2) != 1) begin bad++; $display("[TB] FAIL exh_go2: got %0d want 1", peekI(goRuns, 2)); end
        total++; if (outQ.size() != 1 || peekI(outQ, 0) != 1) begin bad++; $display("[TB] FAIL exh_outcome: got n=%0d code=%0d want n=1 code=1", outQ.size(), peekI(outQ, 0)); end
    endtask

    task automatic test_timeout();
        bit ok;
        clearMon();
        addResp(-1, 1'b0);
        q1.push_back(24'h2B0001);
        waitSettle(1, 200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL tmo_settle: got outcomes=%0d want 1", outQ.size()); end
        total++; if (peekI(goRuns, 0) != TIMEOUT) begin bad++; $display("[TB] FAIL tmo_go_len: got %0d want %0d", peekI(goRuns, 0), TIMEOUT); end
        total++; if (outQ.size() != 1 || peekI(outQ, 0) != 3) begin bad++; $display("[TB] FAIL tmo_outcome: got n=%0d code=%0d want n=1 code=3", outQ.size(), peekI(outQ, 0)); end
        clearMon();
        addResp(TIMEOUT - 1, 1'b0);
        q0.push_back(24'h2B0002);
        waitSettle(1, 200, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL tie_settle: got outcomes=%0d want 1", outQ.size()); end
        total++; if (peekI(goRuns, 0) != TIMEOUT) begin bad++; $display("[TB] FAIL tie_go_len: got %0d want %0d", peekI(goRuns, 0), TIMEOUT); end
        total++; if (outQ.size() != 1 || peekI(outQ, 0) != 0) begin bad++; $display("[TB] FAIL tie_outcome: got n=%0d code=%0d want n=1 code=0", outQ.size(), peekI(outQ, 0)); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int g = 0;
        clearMon();
        addResp(-1, 1'b0);
        q0.push_back(24'hC30011);
        while (i2c_go !== 1'b1 && g < 20) begin tick(); g++; end
        total++; if (i2c_go !== 1'b1) begin bad++; $display("[TB] FAIL rmid_start: got go=%b want 1", i2c_go); end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        total++; if (i2c_go !== 1'b0) begin bad++; $display("[TB] FAIL rmid_go: got %b want 0", i2c_go); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy: got %b want 0", busy); end
        reset = 1'b0;
        repeat (6) tick();
        total++; if (outQ.size() != 0) begin bad++; $display("[TB] FAIL rmid_no_pulse: got %0d outcomes want 0", outQ.size()); end
        addResp(3, 1'b0);
        q1.push_back(24'h401500);
        waitSettle(1, 200, ok);
        total++; if (!ok || outQ.size() != 1 || peekI(outQ, 0) != 2) begin bad++; $display("[TB] FAIL rmid_after: got n=%0d code=%0d want n=1 code=2", outQ.size(), peekI(outQ, 0)); end
        total++; if (peekD(dataQ, 1) != 32'h401500) begin bad++; $display("[TB] FAIL rmid_data: got %h want 401500", peekD(dataQ, 1)); end
    endtask

    task automatic test_random();
        bit ok;
        int n0, n1, nAtt, i0, i1, turn, k, who, result, dly;
        bit first;
        logic ack;
        logic [23:0] d;
        logic [23:0] d0[$], d1[$];
        int rd[$];
        logic ra[$];
        int expIds[$], expData[$], expGo[$], expLow[$], expOut[$];

        reset = 1'b1;
        clearMon();
        n0 = $urandom_range(3, 6);
        n1 = $urandom_range(3, 6);
        for (int i = 0; i < n0; i++) begin d = 24'($urandom); d0.push_back(d); q0.push_back(d); end
        for (int i = 0; i < n1; i++) begin d = 24'($urandom); d1.push_back(d); q1.push_back(d); end
        nAtt = (n0 + n1) * (RETRIES + 1);
        for (int i = 0; i < nAtt; i++) begin
            int sel = $urandom_range(0, 9);
            dly = (sel == 0) ? -1 : (sel == 1) ? TIMEOUT - 1 : $urandom_range(0, 6);
            ack = 1'($urandom_range(0, 1));
            rd.push_back(dly); ra.push_back(ack);
            addResp(dly, ack);
        end

        // Command-level expectation: alternate while both have work, walk each attempt's response.
        i0 = 0; i1 = 0; turn = 0; k = 0; first = 1;
        while (i0 < n0 || i1 < n1) begin
            who = ((turn == 0 && i0 < n0) || i1 >= n1) ? 0 : 1;
            if (who == 0) begin d = d0[i0]; i0++; end else begin d = d1[i1]; i1++; end
            turn = 1 - who;
            expIds.push_back(who);
            result = 1;
            for (int att = 1; att <= RETRIES + 1; att++) begin
                if (!first) expLow.push_back(att == 1 ? GAP + 1 : GAP);
                first = 0;
                expData.push_back(int'(d));
                dly = rd[k]; ack = ra[k]; k++;
                if (dly < 0) begin expGo.push_back(TIMEOUT); result = 1; break; end
                expGo.push_back(dly + 1);
                if (!ack) begin result = 0; break; end
            end
            expOut.push_back(who * 2 + result);
        end

        tick(); tick();
        reset = 1'b0;
        waitSettle(n0 + n1, 4000, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rnd_settle: got outcomes=%0d want %0d", outQ.size(), n0 + n1); end
        total++; if (outQ.size() != expOut.size()) begin bad++; $display("[TB] FAIL rnd_out_count: got %0d want %0d", outQ.size(), expOut.size()); end
        total++; if (dataQ.size() != expData.size()) begin bad++; $display("[TB] FAIL rnd_attempts: got %0d want %0d", dataQ.size(), expData.size()); end
        foreach (expIds[i]) begin
            total++; if (peekI(readyQ, i) != expIds[i]) begin bad++; $display("[TB] FAIL rnd_grant%0d: got %0d want %0d", i, peekI(readyQ, i), expIds[i]); end
            total++; if (peekI(outQ, i) != expOut[i]) begin bad++; $display("[TB] FAIL rnd_out%0d: got %0d want %0d", i, peekI(outQ, i), expOut[i]); end
        end
        foreach (expData[i]) begin
            total++; if (peekD(dataQ, i) != expData[i]) begin bad++; $display("[TB] FAIL rnd_data%0d: got %h want %h", i, peekD(dataQ, i), expData[i]); end
            total++; if (peekI(goRuns, i) != expGo[i]) begin bad++; $display("[TB] FAIL rnd_go%0d: got %0d want %0d", i, peekI(goRuns, i), expGo[i]); end
        end
        foreach (expLow[i]) begin
            total++; if (peekI(lowRuns, i) != expLow[i]) begin bad++; $display("[TB] FAIL rnd_gap%0d: got %0d want %0d", i, peekI(lowRuns, i), expLow[i]); end
        end
        total++; if (widthErr != 0) begin bad++; $display("[TB] FAIL pulse_width: got %0d wide pulses want 0", widthErr); end
        total++; if (dataChg != 0) begin bad++; $display("[TB] FAIL data_stable: got %0d changes while go want 0", dataChg); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_retry();
        test_exhaust();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
